// File: rtl/trigger_event_queue.sv
// trigger_event_queue: captures single-clk event pulses, queues them as 2-bit codes and
// presents them one at a time as a held one-hot word to the trigger output encoder.
// Lost events (multi-hot inputs, enqueue into a full queue) are counted in a saturating counter.
module trigger_event_queue #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_sync,
   input  logic [3:0]               i_ev_in,
   output logic [4:0]               o_trigger_out,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_busy,
   input  logic                     i_drop_clr,
   output logic [15:0]              o_drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   typedef enum logic [1:0] {StIdle, StPresent, StHold} state_e;

   state_e          r_state, w_state_nx;
   logic [1:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]   r_level, w_level_nx;
   logic [4:0]      r_trigger_out, w_trigger_nx;
   logic [1:0]      r_hold_cnt, w_hold_nx;
   logic [15:0]     r_drop_cnt;

   logic            w_push, w_push_ok, w_pop, w_full, w_drop_full;
   logic [1:0]      w_code, w_head;
   logic [2:0]      w_ev_cnt, w_extra, w_drops;
   logic [16:0]     w_drop_sum;

   function automatic logic [4:0] f_onehot(input logic [1:0] code);
      return 5'd1 << code;
   endfunction

   // Number of encoder syncs the frame of each event keeps the encoder busy.
   function automatic logic [1:0] f_hold(input logic [1:0] code);
      logic [1:0] h;
      unique case (code)
         2'd0:    h = 2'd1;
         2'd1:    h = 2'd2;
         default: h = 2'd3;
      endcase
      return h;
   endfunction

   // Input priority encode, drop accounting and FIFO push/pop qualification.
   always_comb begin
      w_push = |i_ev_in;
      w_code = 2'd0;
      if (i_ev_in[0])      w_code = 2'd0;
      else if (i_ev_in[1]) w_code = 2'd1;
      else if (i_ev_in[2]) w_code = 2'd2;
      else if (i_ev_in[3]) w_code = 2'd3;
      w_ev_cnt    = 3'(i_ev_in[0]) + 3'(i_ev_in[1]) + 3'(i_ev_in[2]) + 3'(i_ev_in[3]);
      w_extra     = w_ev_cnt - 3'(w_push);
      w_full      = (r_level == LW'(DEPTH));
      w_pop       = (r_state == StPresent) && i_sync;
      // A pop in the same clk frees a slot, so a full queue can still accept.
      w_push_ok   = w_push && (!w_full || w_pop);
      w_drop_full = w_push && !w_push_ok;
      w_drops     = w_extra + 3'(w_drop_full);
      w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drops);
      w_level_nx  = r_level + LW'(w_push_ok) - LW'(w_pop);
      // Bypass the write when empty so HOLD can load an event pushed in the same clk.
      w_head      = (r_level == '0) ? w_code : r_mem[r_rd_ptr];
   end

   // State, pointers, occupancy, presented word, hold counter and drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= StIdle;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_trigger_out <= '0;
         r_hold_cnt    <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_level       <= w_level_nx;
         r_trigger_out <= w_trigger_nx;
         r_hold_cnt    <= w_hold_nx;
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
         if (i_drop_clr)         r_drop_cnt <= '0;
         else if (w_drop_sum[16]) r_drop_cnt <= 16'hFFFF;
         else                     r_drop_cnt <= w_drop_sum[15:0];
      end
   end

   // FIFO storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= w_code;
   end

   // Next-state logic.
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         StIdle:    if (r_level != '0) w_state_nx = StPresent;
         StPresent: if (i_sync) w_state_nx = StHold;
         StHold: begin
            if (i_sync && (r_hold_cnt == 2'd1)) begin
               w_state_nx = (w_level_nx != '0) ? StPresent : StIdle;
            end
         end
         default:   w_state_nx = StIdle;
      endcase
   end

   // Next values of the registered outputs: presented word and hold counter.
   always_comb begin
      w_trigger_nx = r_trigger_out;
      w_hold_nx    = r_hold_cnt;
      unique case (r_state)
         StIdle: begin
            if (r_level != '0) w_trigger_nx = f_onehot(w_head);
         end
         StPresent: begin
            if (i_sync) begin
               w_trigger_nx = '0;
               w_hold_nx    = f_hold(w_head);
            end
         end
         StHold: begin
            if (i_sync) begin
               w_hold_nx = r_hold_cnt - 2'd1;
               if ((r_hold_cnt == 2'd1) && (w_level_nx != '0)) w_trigger_nx = f_onehot(w_head);
            end
         end
         default: w_trigger_nx = '0;
      endcase
   end

   assign o_trigger_out = r_trigger_out;
   assign o_level       = r_level;
   assign o_full        = w_full;
   assign o_busy        = (r_state != StIdle) || (r_level != '0);
   assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_trigger_event_queue.sv
// Directed self-checking bench for trigger_event_queue (DEPTH=8).
module tb_trigger_event_queue;

   localparam int unsigned DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        sync;
   logic [3:0]  ev_in;
   logic        drop_clr;
   logic [4:0]  trigger_out;
   logic [3:0]  level;
   logic        full;
   logic        busy;
   logic [15:0] drop_cnt;

   int n_total = 0;
   int n_bad   = 0;

   trigger_event_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_sync       (sync),
      .i_ev_in      (ev_in),
      .o_trigger_out(trigger_out),
      .o_level      (level),
      .o_full       (full),
      .o_busy       (busy),
      .i_drop_clr   (drop_clr),
      .o_drop_cnt   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n clocks; leaves time at 1 unit after the last rising edge.
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_sync();
      sync = 1'b1;
      step();
      sync = 1'b0;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   logic [4:0] exp3 [7];

   initial begin
      reset    = 1'b1;
      sync     = 1'b0;
      ev_in    = 4'b0000;
      drop_clr = 1'b0;
      #1;
      check_eq("rst trigger_out", 32'(trigger_out), 32'h0);
      check_eq("rst level", 32'(level), 32'h0);
      check_eq("rst full", 32'(full), 32'h0);
      check_eq("rst busy", 32'(busy), 32'h0);
      check_eq("rst drop_cnt", 32'(drop_cnt), 32'h0);
      step(2);
      reset = 1'b0;
      step();

      // 1: single trg, presented two clks later, then two syncs of hold
      ev_in = 4'b0010;
      step();
      ev_in = 4'b0000;
      check_eq("t1 trig n+1", 32'(trigger_out), 32'h0);
      check_eq("t1 level n+1", 32'(level), 32'h1);
      step();
      check_eq("t1 trig n+2", 32'(trigger_out), 32'h02);
      step(2);
      check_eq("t1 trig held", 32'(trigger_out), 32'h02);
      pulse_sync();
      check_eq("t1 trig taken", 32'(trigger_out), 32'h0);
      check_eq("t1 level taken", 32'(level), 32'h0);
      check_eq("t1 busy hold", 32'(busy), 32'h1);
      step(3);
      pulse_sync();
      check_eq("t1 busy hold2", 32'(busy), 32'h1);
      check_eq("t1 trig hold2", 32'(trigger_out), 32'h0);
      step(3);
      pulse_sync();
      check_eq("t1 busy idle", 32'(busy), 32'h0);
      check_eq("t1 drop_cnt", 32'(drop_cnt), 32'h0);

      // 2: all four bits at once, then asynchronous reset while presenting
      do_reset();
      ev_in = 4'b1111;
      step();
      ev_in = 4'b0000;
      step();
      check_eq("t2 trig syn", 32'(trigger_out), 32'h01);
      check_eq("t2 drop_cnt", 32'(drop_cnt), 32'h3);
      check_eq("t2 level", 32'(level), 32'h1);
      #2 reset = 1'b1;
      #1;
      check_eq("t2 async trig", 32'(trigger_out), 32'h0);
      check_eq("t2 async level", 32'(level), 32'h0);
      check_eq("t2 async busy", 32'(busy), 32'h0);
      step();
      reset = 1'b0;

      // 3: syn, rsr, rst back to back; takes at syncs k, k+2, k+6
      ev_in = 4'b0001;
      step();
      ev_in = 4'b0100;
      step();
      ev_in = 4'b1000;
      step();
      ev_in = 4'b0000;
      step(2);
      check_eq("t3 level", 32'(level), 32'h3);
      exp3 = '{5'h01, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00, 5'h08};
      for (int i = 0; i < 7; i++) begin
         check_eq($sformatf("t3 pre-sync %0d", i), 32'(trigger_out), 32'(exp3[i]));
         pulse_sync();
         step(2);
      end
      check_eq("t3 level end", 32'(level), 32'h0);

      // 4: fill past capacity, then simultaneous pop and push while full
      do_reset();
      for (int i = 0; i < 10; i++) begin
         ev_in = 4'b0010;
         step();
      end
      ev_in = 4'b0000;
      check_eq("t4 level", 32'(level), 32'h8);
      check_eq("t4 full", 32'(full), 32'h1);
      check_eq("t4 drop_cnt", 32'(drop_cnt), 32'h2);
      check_eq("t4 trig", 32'(trigger_out), 32'h02);
      sync  = 1'b1;
      ev_in = 4'b0100;
      step();
      sync  = 1'b0;
      ev_in = 4'b0000;
      check_eq("t4 level pp", 32'(level), 32'h8);
      check_eq("t4 full pp", 32'(full), 32'h1);
      check_eq("t4 drop_cnt pp", 32'(drop_cnt), 32'h2);
      check_eq("t4 trig pp", 32'(trigger_out), 32'h0);

      // 5: drive drop_cnt to FFFE with the queue full, saturate, then clear vs drop
      drop_clr = 1'b1;
      step();
      drop_clr = 1'b0;
      check_eq("t5 clr", 32'(drop_cnt), 32'h0);
      ev_in = 4'b1111;
      step();
      check_eq("t5 four drops", 32'(drop_cnt), 32'h4);
      step(16382);
      ev_in = 4'b0011;
      step();
      ev_in = 4'b0000;
      check_eq("t5 preload", 32'(drop_cnt), 32'hFFFE);
      ev_in = 4'b0111;
      step();
      ev_in = 4'b0000;
      check_eq("t5 saturate", 32'(drop_cnt), 32'hFFFF);
      drop_clr = 1'b1;
      ev_in    = 4'b0011;
      step();
      drop_clr = 1'b0;
      ev_in    = 4'b0000;
      check_eq("t5 clr wins", 32'(drop_cnt), 32'h0);

      // 6: reset in HOLD with three entries queued, then recovery
      do_reset();
      ev_in = 4'b0010;
      step();
      ev_in = 4'b0001;
      step(3);
      ev_in = 4'b0000;
      step(2);
      check_eq("t6 trig", 32'(trigger_out), 32'h02);
      check_eq("t6 level", 32'(level), 32'h4);
      pulse_sync();
      check_eq("t6 level hold", 32'(level), 32'h3);
      check_eq("t6 busy hold", 32'(busy), 32'h1);
      #2 reset = 1'b1;
      #1;
      check_eq("t6 async trig", 32'(trigger_out), 32'h0);
      check_eq("t6 async level", 32'(level), 32'h0);
      check_eq("t6 async busy", 32'(busy), 32'h0);
      check_eq("t6 async full", 32'(full), 32'h0);
      step();
      reset = 1'b0;
      ev_in = 4'b1000;
      step();
      ev_in = 4'b0000;
      step();
      check_eq("t6 after reset", 32'(trigger_out), 32'h08);
      check_eq("t6 drop_cnt", 32'(drop_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
